sd_kin_sequencer: RTL

- Programmable schedule controller for the two-input sigma-delta datapath (kin1/kin2 words, muxin1 select).
- Holds a table of DEPTH input words, each with a dwell count, and steps through them in order.
- Uses ping-pong switching: the inactive kin port is always preloaded with the next word, so a segment change is a single muxin1 toggle and the modulator input never glitches.
- Sits between the configuration interface and the modulator; its kin1/kin2/muxin1 outputs connect directly to the modulator inputs.

---
 rtl/sd_kin_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sd_kin_sequencer.sv
// Ping-pong schedule controller for the two-input sigma-delta modulator.
// Steps through a table of {word, dwell} entries and preloads the idle kin port with the next word.
module sd_kin_sequencer #(
  parameter int BITWIDTH = 40,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int CNTW     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [BITWIDTH-1:0] cfg_value,
  input  logic [CNTW-1:0]     cfg_dwell,
  input  logic [AW:0]         cfg_len,
  input  logic                loop,
  input  logic                start,
  input  logic                stop,
  output logic [BITWIDTH-1:0] kin1,
  output logic [BITWIDTH-1:0] kin2,
  output logic                muxin1,
  output logic [AW-1:0]       seg_idx,
  output logic                busy,
  output logic                done
);

  // state | meaning
  // IDLE  | outputs hold, table writable, waiting for start
  // RUN   | presenting entries, dwell counter active
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t              state;
  logic [BITWIDTH-1:0] tbl_value [DEPTH];
  logic [CNTW-1:0]     tbl_dwell [DEPTH];
  logic [CNTW-1:0]     cnt;
  logic [AW:0]         len_r;
  logic                loop_r;

  logic [AW:0]         len_eff;
  logic                last_seg;
  logic [AW-1:0]       nxt_idx;
  logic [AW-1:0]       reload_idx;
  logic [AW-1:0]       start_kin2_idx;

  function automatic logic [CNTW-1:0] eff_dwell(input logic [CNTW-1:0] d);
    return (d == '0) ? CNTW'(1) : d;
  endfunction

  always_comb begin
    len_eff        = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
    start_kin2_idx = (len_eff == (AW+1)'(1)) ? '0 : AW'(1);
    last_seg       = ({1'b0, seg_idx} == (len_r - (AW+1)'(1)));
    nxt_idx        = last_seg ? '0 : seg_idx + AW'(1);
    // Word to preload behind the newly selected port: the entry after nxt, wrapping at len_r.
    reload_idx     = (({1'b0, nxt_idx} + (AW+1)'(1)) == len_r) ? '0 : nxt_idx + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_value[i] <= '0;
        tbl_dwell[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tbl_value[cfg_addr] <= cfg_value;
      tbl_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      kin1    <= '0;
      kin2    <= '0;
      muxin1  <= 1'b0;
      seg_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      len_r   <= '0;
      loop_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop && (len_eff != '0)) begin
            kin1    <= tbl_value[0];
            kin2    <= tbl_value[start_kin2_idx];
            muxin1  <= 1'b0;
            seg_idx <= '0;
            cnt     <= eff_dwell(tbl_dwell[0]);
            len_r   <= len_eff;
            loop_r  <= loop;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt > CNTW'(1)) begin
            cnt <= cnt - CNTW'(1);
          end else if (last_seg && !loop_r) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            // Only the port being switched away from is rewritten, so the selected word never glitches.
            muxin1  <= ~muxin1;
            seg_idx <= nxt_idx;
            cnt     <= eff_dwell(tbl_dwell[nxt_idx]);
            if (!muxin1) kin1 <= tbl_value[reload_idx];
            else         kin2 <= tbl_value[reload_idx];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
